// File: rtl/term_loopback_cfg.sv
// term_loopback_cfg: edge-tile END->BEG loopback with per-channel
// direct / registered / tie0 / tie1 modes, configured over a serial
// shadow chain and applied atomically on a commit strobe.
// Ports:
//   UserCLK, RST       clock, async active-high reset
//   end_in / beg_out   N_WIRES looped wires (index reversed)
//   cfg_shift_en/din   serial shadow-chain shift and data in
//   cfg_dout           shadow MSB, for daisy-chaining
//   cfg_commit         shadow -> active copy request
//   cfg_busy           high while the pipeline refills after a commit
module term_loopback_cfg #(
   parameter int N_WIRES    = 52,
   parameter int PIPE_DEPTH = 1
) (
   input  logic               UserCLK,
   input  logic               RST,
   input  logic [N_WIRES-1:0] end_in,
   output logic [N_WIRES-1:0] beg_out,
   input  logic               cfg_shift_en,
   input  logic               cfg_din,
   output logic               cfg_dout,
   input  logic               cfg_commit,
   output logic               cfg_busy
);

   localparam int CW = 2 * N_WIRES;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   localparam logic [2:0] CNT_INIT = 3'(PIPE_DEPTH - 1);

   generate
      if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
         $error("PIPE_DEPTH must be in 1..8");
      end
   endgenerate

   logic [N_WIRES-1:0] rev;

   logic [CW-1:0]      shadow_q, shadow_d;
   logic [CW-1:0]      active_q, active_d;
   logic [0:0]         state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [N_WIRES-1:0] pipe_q [PIPE_DEPTH];
   logic [N_WIRES-1:0] pipe_d [PIPE_DEPTH];

   logic commit_go;

   always_comb begin
      rev = '0;
      for (int i = 0; i < N_WIRES; i++) begin
         rev[i] = end_in[N_WIRES-1-i];
      end
   end

   assign commit_go = (state_q == S_IDLE) && cfg_commit;

   // Commit reads shadow_q, so a same-cycle shift commits the old value.
   always_comb begin
      shadow_d = shadow_q;
      if (cfg_shift_en) begin
         shadow_d = {shadow_q[CW-2:0], cfg_din};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_commit) begin
               active_d = shadow_q;
               cnt_d    = CNT_INIT;
               state_d  = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 3'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pipeline runs every cycle; a commit clears it so stale data
   // from the previous mode never reaches a REG channel.
   always_comb begin
      pipe_d[0] = commit_go ? '0 : rev;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         pipe_d[k] = commit_go ? '0 : pipe_q[k-1];
      end
   end

   always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
         shadow_q <= '0;
         active_q <= '0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   always_comb begin
      beg_out = '0;
      for (int i = 0; i < N_WIRES; i++) begin
         case (active_q[2*i +: 2])
            2'b00:   beg_out[i] = rev[i];
            2'b01:   beg_out[i] = pipe_q[PIPE_DEPTH-1][i];
            2'b10:   beg_out[i] = 1'b0;
            default: beg_out[i] = 1'b1;
         endcase
      end
   end

   assign cfg_dout = shadow_q[CW-1];
   assign cfg_busy = (state_q == S_FLUSH);

endmodule

// File: tb/tb_term_loopback_cfg.sv
// tb_term_loopback_cfg: self-checking bench for term_loopback_cfg
// (N_WIRES=8, PIPE_DEPTH=2, plus a PIPE_DEPTH=8 instance).
module tb_term_loopback_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ein, bout;
   logic       sen, din, dout, cmt, busy;
   logic [7:0] ein8, bout8;
   logic       sen8, din8, dout8, cmt8, busy8;

   int checks = 0;
   int fails  = 0;

   logic sb_q [$];

   typedef struct {
      logic [7:0] ein;
      logic [7:0] bexp;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   term_loopback_cfg #(.N_WIRES(8), .PIPE_DEPTH(2)) dut (
      .UserCLK(clk), .RST(rst), .end_in(ein), .beg_out(bout),
      .cfg_shift_en(sen), .cfg_din(din), .cfg_dout(dout),
      .cfg_commit(cmt), .cfg_busy(busy)
   );

   term_loopback_cfg #(.N_WIRES(8), .PIPE_DEPTH(8)) dut8 (
      .UserCLK(clk), .RST(rst), .end_in(ein8), .beg_out(bout8),
      .cfg_shift_en(sen8), .cfg_din(din8), .cfg_dout(dout8),
      .cfg_commit(cmt8), .cfg_busy(busy8)
   );

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      sen = 1'b1;
      din = b;
      cyc();
      sen = 1'b0;
   endtask

   task automatic shift16(input logic [15:0] v, input bit push);
      for (int i = 15; i >= 0; i--) begin
         if (push) sb_q.push_back(v[i]);
         shift_bit(v[i]);
      end
   endtask

   task automatic commit();
      cmt = 1'b1;
      cyc();
      cmt = 1'b0;
   endtask

   initial begin
      logic       seq [6];
      logic [7:0] r;
      logic [15:0] sv;
      int n;

      tbl[0] = '{8'h01, 8'h80};
      tbl[1] = '{8'h35, 8'hAC};
      tbl[2] = '{8'h0F, 8'hF0};
      tbl[3] = '{8'h12, 8'h48};
      tbl[4] = '{8'hFF, 8'hFF};
      tbl[5] = '{8'h00, 8'h00};
      seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; ein = 8'h00; sen = 0; din = 0; cmt = 0;
      ein8 = 8'h00; sen8 = 0; din8 = 0; cmt8 = 0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_dout", dout, 1'b0);
      chk("rst_busy8", busy8, 1'b0);
      #10 rst = 1'b0;
      cyc();

      // 1: legacy reversed mapping, combinational
      for (int i = 0; i < 6; i++) begin
         ein = tbl[i].ein;
         #1;
         chk($sformatf("t1_beg[%0d]", i), bout, tbl[i].bexp);
         chk("t1_busy", busy, 1'b0);
      end

      // 2: ch0 registered, 2-cycle latency after flush
      ein = 8'h00;
      shift16(16'h0001, 0);
      commit();
      sb_q.delete();
      sb_q.push_back(1'b0);
      sb_q.push_back(1'b0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("t2_beg0[%0d]", k), bout[0], sb_q.pop_front());
         chk($sformatf("t2_busy[%0d]", k), busy, (k < 2));
         ein = {seq[k], 7'b0};
         sb_q.push_back(seq[k]);
         cyc();
      end
      sb_q.delete();

      // 3: ch1 tie0, ch2 tie1
      shift16(16'h0038, 0);
      commit();
      for (int k = 0; k < 8; k++) begin
         ein = 8'($urandom);
         #1;
         r = (rev8(ein) & 8'hFD) | 8'h04;
         chk($sformatf("t3_beg[%0d]", k), bout, r);
      end
      cyc();
      cyc();

      // 4: commit in FLUSH ignored; cfg_dout replay
      shift16(16'h00C0, 0);
      commit();
      cmt = 1'b1; sen = 1'b1; din = 1'b0;
      cyc();
      cmt = 1'b0; sen = 1'b0;
      ein = 8'h00;
      #1;
      chk("t4_beg_flush", bout, 8'h08);
      chk("t4_busy_flush", busy, 1'b1);
      cyc();
      chk("t4_busy_done", busy, 1'b0);
      chk("t4_beg_done", bout, 8'h08);
      sb_q.delete();
      shift16(16'hB3C5, 1);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t4_dout[%0d]", k), dout, sb_q.pop_front());
         shift_bit(1'b0);
      end

      // 5: async reset mid-flush
      shift16(16'hAAAA, 0);
      commit();
      ein = 8'h35;
      #1;
      chk("t5_beg_tie0", bout, 8'h00);
      chk("t5_busy_pre", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t5_busy_rst", busy, 1'b0);
      chk("t5_beg_rst", bout, 8'hAC);
      chk("t5_dout_rst", dout, 1'b0);
      #1 rst = 1'b0;
      cyc();
      chk("t5_beg_post", bout, 8'hAC);
      chk("t5_busy_post", busy, 1'b0);

      // 6: same-cycle shift+commit commits pre-shift shadow
      shift16(16'h0003, 0);
      ein = 8'h40;
      cmt = 1'b1; sen = 1'b1; din = 1'b1;
      cyc();
      cmt = 1'b0; sen = 1'b0;
      #1;
      chk("t6_beg", bout, 8'h03);
      cyc();
      cyc();
      chk("t6_busy", busy, 1'b0);
      sv = 16'h0007;
      for (int k = 15; k >= 0; k--) begin
         chk($sformatf("t6_shadow[%0d]", k), dout, sv[k]);
         shift_bit(1'b0);
      end

      // 6b: PIPE_DEPTH=8 busy length
      cmt8 = 1'b1;
      cyc();
      cmt8 = 1'b0;
      n = 0;
      while (busy8 && n < 40) begin
         n++;
         cyc();
      end
      chk("t6_busy8_len", n, 8);
      chk("t6_busy8_low", busy8, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
